// File: rtl/fe_pkg.sv
// Shared front-end definitions for the sqrt engine arbiter and related
// shared-resource arbiters.
//   state_e    : arbiter FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   DATA_W_DEF : default operand/result width
//   REQ_MAG    : requester index of the accelerometer magnitude path
//   REQ_STD    : requester index of the windowed-statistics std-dev path
package fe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int DATA_W_DEF = 16;

  localparam int REQ_MAG = 0;
  localparam int REQ_STD = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at ptr, wrapping from NUM_REQ-1 back to 0, and
// reports the first set bit.
// Ports:
//   req       in  NUM_REQ  request vector
//   ptr       in  IDX_W    index with highest priority this round
//   any       out 1        at least one request present
//   grant_idx out IDX_W    index of the winner (0 when any is low)
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the candidate closest to ptr
  // is the last one written and therefore wins.
  always_comb begin
    any       = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/sqrt_engine_arbiter.sv
// Round-robin arbiter/sequencer sharing one cordic_sqrt engine among
// NUM_REQ requesters. One operation in flight at a time: latch operands,
// pulse eng_start, wait for eng_valid, return result with a one-cycle done.
//
// Optional feature: define SQRT_ARB_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES). Without it WAIT is unbounded and err is tied low.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req[NUM_REQ]            level request per requester
//   req_x/y/z               packed operands, requester i at [i*DATA_W +: DATA_W]
//   done[NUM_REQ]           one-hot result pulse to the owner
//   result[DATA_W]          result, held until the next done
//   err                     done carries a timed-out (zero) result
//   busy                    FSM not in IDLE
//   eng_start               one-cycle engine start
//   eng_x/y/z[DATA_W]       latched operands to the engine
//   eng_result, eng_valid   engine response
//
// state | meaning
// IDLE  | waiting for any req, picks winner round-robin and latches operands
// ISSUE | eng_start high for this single cycle
// WAIT  | waiting for eng_valid (or watchdog expiry)
// RESP  | done[g] (and err) visible for one cycle
module sqrt_engine_arbiter
  import fe_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  input  logic [NUM_REQ*DATA_W-1:0] req_z,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         result,
  output logic                      err,
  output logic                      busy,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_x,
  output logic [DATA_W-1:0]         eng_y,
  output logic [DATA_W-1:0]         eng_z,
  input  logic [DATA_W-1:0]         eng_result,
  input  logic                      eng_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sqrt_engine_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sqrt_engine_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    g_q, g_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   eng_x_q, eng_x_d;
  logic [DATA_W-1:0]   eng_y_q, eng_y_d;
  logic [DATA_W-1:0]   eng_z_q, eng_z_d;

  logic                pick_any;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    ptr_next;

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req       (req),
    .ptr       (ptr_q),
    .any       (pick_any),
    .grant_idx (pick_idx)
  );

  // The owner just served drops to lowest priority for the next round.
  assign ptr_next = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    ptr_d    = ptr_q;
    done_d   = '0;
    result_d = result_q;
    eng_x_d  = eng_x_q;
    eng_y_d  = eng_y_q;
    eng_z_d  = eng_z_q;
`ifdef SQRT_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          g_d = pick_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
              eng_x_d = req_x[i*DATA_W +: DATA_W];
              eng_y_d = req_y[i*DATA_W +: DATA_W];
              eng_z_d = req_z[i*DATA_W +: DATA_W];
            end
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef SQRT_ARB_TIMEOUT_EN
        tmo_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_valid) begin
          result_d    = eng_result;
          done_d[g_q] = 1'b1;
          ptr_d       = ptr_next;
          state_d     = ST_RESP;
        end
`ifdef SQRT_ARB_TIMEOUT_EN
        // tmo_q counts completed WAIT cycles; this is the last one allowed.
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          result_d    = '0;
          done_d[g_q] = 1'b1;
          err_d       = 1'b1;
          ptr_d       = ptr_next;
          state_d     = ST_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      ptr_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      eng_x_q  <= '0;
      eng_y_q  <= '0;
      eng_z_q  <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      result_q <= result_d;
      eng_x_q  <= eng_x_d;
      eng_y_q  <= eng_y_d;
      eng_z_q  <= eng_z_d;
`ifdef SQRT_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  assign done      = done_q;
  assign result    = result_q;
  assign eng_x     = eng_x_q;
  assign eng_y     = eng_y_q;
  assign eng_z     = eng_z_q;
  assign busy      = (state_q != ST_IDLE);
  assign eng_start = (state_q == ST_ISSUE);

`ifdef SQRT_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
